// File: rtl/mac_dot_sequencer_pkg.sv
// Shared fixed-point constants and state encoding for the MAC dot-product sequencer.
package mac_dot_sequencer_pkg;

  localparam int SEQ_ADDR_W = 8;
  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_FRAC_W = 12;
  localparam int SEQ_ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Sequences a sibling mac_unit through one dot product: operand fetch, bias-seeded
// accumulation with result feedback, and a valid/ready hand-off of the final sum.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one operand read per cycle (terms 0..L-1)
// DRAIN | waiting for the last calculate to land in mac_result
// HOLD  | out_valid high until out_ready; may accept the next job directly
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ACC_W  = SEQ_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ACC_W-1:0]  bias,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              mac_calculate,
  output logic [DATA_W-1:0] mac_tem1,
  output logic [DATA_W-1:0] mac_tem2,
  output logic [ACC_W-1:0]  mac_tem3,
  input  logic [ACC_W-1:0]  mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  seq_state_t        state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [ACC_W-1:0]  bias_q;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] k_next;
  logic              dv;
  logic              dv_first;
  logic              accept;

  assign accept = start && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign k_next = k + ADDR_W'(1);

  // Operand data arrives one cycle after rd_en, so dv marks the compute cycle.
  assign mac_calculate = dv;
  assign mac_tem1      = dv ? a_data : '0;
  assign mac_tem2      = dv ? b_data : '0;
  assign mac_tem3      = !dv ? '0 : (dv_first ? bias_q : mac_result);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      a_addr    <= '0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      len_q     <= '0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      bias_q    <= '0;
      k         <= '0;
      dv        <= 1'b0;
      dv_first  <= 1'b0;
    end else begin
      dv       <= rd_en;
      dv_first <= rd_en && (k == '0);
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            len_q     <= len;
            a_base_q  <= a_base;
            b_base_q  <= b_base;
            bias_q    <= bias;
            k         <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            if (len != '0) begin
              state  <= FETCH;
              rd_en  <= 1'b1;
              a_addr <= a_base;
              b_addr <= b_base;
            end else begin
              state <= DRAIN;
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        FETCH: begin
          if (k == (len_q - ADDR_W'(1))) begin
            state  <= DRAIN;
            rd_en  <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
          end else begin
            k      <= k_next;
            a_addr <= a_base_q + k_next;
            b_addr <= b_base_q + k_next;
          end
        end
        DRAIN: begin
          // Once no calculate is in flight, mac_result holds the final sum.
          if (!dv) begin
            out_data  <= (len_q == '0) ? bias_q : mac_result;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Controller that sequences the shared fixed-point MAC unit (16-bit Q4.12 operands, 32-bit accumulator) through a dot product of length L.
- Fetches operand pairs from two synchronous-read operand memories (A and B).
- Drives the MAC's calculate/tem1/tem2/tem3 inputs, seeding the first term with a bias and feeding back the MAC result for the remaining terms.
- Returns the final sum through a valid/ready output handshake.
- Sits between the layer scheduler (job issue) and the mac_unit instance, which is a sibling, not a child.

Parameters:
ADDR_W, 8, operand memory address width; also the width of len.
DATA_W, 16, operand width (Q4.12).
ACC_W, 32, accumulator/result width.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-low. reset==0 at a clk edge clears the block.
start  in  1  job request; sampled only when accepting.
len  in  ADDR_W  number of terms L; 0 is legal.
a_base  in  ADDR_W  first A address.
b_base  in  ADDR_W  first B address.
bias  in  ACC_W  initial accumulator value.
busy  out  1  high whenever state != IDLE.
rd_en  out  1  read strobe to both memories.
a_addr  out  ADDR_W  A read address.
b_addr  out  ADDR_W  B read address.
a_data  in  DATA_W  A read data, valid the cycle after rd_en.
b_data  in  DATA_W  B read data, valid the cycle after rd_en.
mac_calculate  out  1  to mac_unit calculate.
mac_tem1  out  DATA_W  to mac_unit tem1.
mac_tem2  out  DATA_W  to mac_unit tem2.
mac_tem3  out  ACC_W  to mac_unit tem3.
mac_result  in  ACC_W  from mac_unit result; updates one edge after calculate.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts.
out_data  out  ACC_W  final dot product.

Behaviour:
- States: IDLE, FETCH, DRAIN, HOLD.
- Reset (reset==0 at an edge), from any state:
  - state=IDLE; all outputs 0: busy, rd_en, addresses, mac_* and out_valid=0; out_data=0.
  - An in-flight job is discarded.
  - The mac_unit register is not cleared by this block. This is harmless because the first term of every job uses bias.
- Accept: in IDLE with start=1 (cycle 0), latch len, a_base, b_base and bias; clear term counter k. If L>0, go to FETCH; if L==0, go to DRAIN.
- FETCH, cycles 1..L:
  - rd_en=1, a_addr=a_base+k, b_addr=b_base+k for k=0..L-1.
  - Address addition wraps modulo 2^ADDR_W.
  - After k=L-1, go to DRAIN.
- Compute, cycles 2..L+1, via a one-cycle pipelined "data valid" flag that follows rd_en:
  - mac_calculate=1, mac_tem1=a_data, mac_tem2=b_data.
  - mac_tem3=bias_latched on the first term (cycle 2); mac_tem3=mac_result on each later term.
  - Back-to-back calculate is legal: each term sees the previous sum. Throughput is 1 term/cycle.
- Signals outside the compute window: mac_calculate=0; mac_tem1, mac_tem2 and mac_tem3 are driven 0.
- DRAIN:
  - Entered at cycle L+1 (L>0) or cycle 1 (L==0).
  - DRAIN lasts until the last calculate has landed in mac_result. At the edge ending cycle L+2, capture out_data=mac_result. For L==0, capture out_data=bias_latched at the end of cycle 1, with no calculate issued.
  - Then go to HOLD.
- HOLD:
  - out_valid=1; out_data is stable until the handshake.
  - On out_valid&&out_ready: if start=1 in the same cycle, accept the new job directly (back-to-back); else go to IDLE.
  - out_valid drops the cycle after the handshake.
- start while busy and not in a HOLD handshake cycle: ignored, with no queueing.
- Latency, start accept to first out_valid: L+3 cycles for L>0; 2 cycles for L==0.
- No saturation in this block; arithmetic is the MAC's (Q4.12 × Q4.12 + acc). Overflow behaviour is inherited from the MAC.

Decomposition:
- Shared package (fixed-point constants):
  - DATA_W=16, FRAC_W=12, ACC_W=32.
  - State enumeration: IDLE=0, FETCH=1, DRAIN=2, HOLD=3.
- No sub-module is required.
  - Address/term counter and FSM stay in one module.
  - mac_unit is instantiated beside it at the next level up, with its active-high reset driven by ~reset.

Test Plan:
1. L=3; A=[0x1000,0x2000,0x0800], B=[0x1000,0x1000,0x1000]; bias=0 -> rd_en cycles 1-3; calculate cycles 2-4; mac_tem3 = 0 on the first term, then feedback; out_valid at cycle 6; out_data = 3.5 in MAC format (matches golden mac model).
2. L=0, bias=0x0001_2345 -> no rd_en, no calculate; out_valid at cycle 2; out_data=0x0001_2345.
3. a_base=0xFE, L=4 -> a_addr sequence 0xFE, 0xFF, 0x00, 0x01 (wrap); result correct.
4. HOLD with out_ready=0 for 5 cycles, then out_ready=1 together with start=1 (L=2) -> out_data stable while held; new job accepted on the handshake cycle; next out_valid 5 cycles later.
5. reset=0 during FETCH of an L=8 job, then a new L=1 job with bias=0x10 and A=B=0x1000 -> all outputs 0 after the reset edge; the new result is bias + 1.0 and is not contaminated by the stale MAC value.
6. start pulsed during FETCH and DRAIN -> ignored; busy stays 1; only one out_valid per accepted job.
